// File: rtl/execute_stage.sv
// Execute-stage operand forwarding plus an iterative 32-cycle multiply/divide
// unit that owns the architectural HI/LO registers and stalls the front end.
module execute_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] ReadData1_Ex,
    input  logic [31:0] ReadData2_Ex,
    input  logic [31:0] Imm_Ex,
    input  logic        ALUSrc,
    input  logic [31:0] ALUResult_Mem,
    input  logic [31:0] WriteData_Wb,
    input  logic [2:0]  MulDivOp,
    input  logic        Start,
    input  logic        Flush,
    output logic [31:0] OperandA,
    output logic [31:0] OperandB,
    output logic [31:0] StoreData,
    output logic        Stall,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [4:0] LAST_ITER = 5'(MD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_op_a;
    logic [32:0] r_acc;
    logic [31:0] r_wlo;
    logic [32:0] r_mcand;
    logic        r_is_div;
    logic        r_neg_hi;
    logic        r_neg_lo;
    logic        r_div0;

    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic        w_is_md;
    logic        w_md_start;
    logic        w_mt_wr;
    logic        w_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;

    // Forward muxes: 11 falls through to the register-file value like 00.
    always_comb begin
        w_fwd_a = ReadData1_Ex;
        unique case (ForwardA)
            2'b10:   w_fwd_a = ALUResult_Mem;
            2'b01:   w_fwd_a = WriteData_Wb;
            default: w_fwd_a = ReadData1_Ex;
        endcase
    end

    always_comb begin
        w_fwd_b = ReadData2_Ex;
        unique case (ForwardB)
            2'b10:   w_fwd_b = ALUResult_Mem;
            2'b01:   w_fwd_b = WriteData_Wb;
            default: w_fwd_b = ReadData2_Ex;
        endcase
    end

    assign OperandA  = w_fwd_a;
    assign OperandB  = ALUSrc ? Imm_Ex : w_fwd_b;
    assign StoreData = w_fwd_b;

    assign w_is_md    = (MulDivOp >= OP_MULT) && (MulDivOp <= OP_DIVU);
    assign w_md_start = (r_state == S_IDLE) && Start && w_is_md && !Flush;
    assign w_mt_wr    = (r_state == S_IDLE) && Start && !Flush &&
                        ((MulDivOp == OP_MTHI) || (MulDivOp == OP_MTLO));
    assign Stall      = w_md_start || (r_state == S_BUSY);
    assign Hi         = r_hi;
    assign Lo         = r_lo;

    // Signed ops run on magnitudes; |0x80000000| still fits in 32 bits unsigned.
    assign w_signed = (MulDivOp == OP_MULT) || (MulDivOp == OP_DIV);
    assign w_neg_a  = w_signed && w_fwd_a[31];
    assign w_neg_b  = w_signed && w_fwd_b[31];
    assign w_mag_a  = w_neg_a ? (32'd0 - w_fwd_a) : w_fwd_a;
    assign w_mag_b  = w_neg_b ? (32'd0 - w_fwd_b) : w_fwd_b;

    logic [32:0] w_sum;
    logic [32:0] w_madd;
    logic [33:0] w_shift;
    logic [34:0] w_diff;
    logic        w_ge;
    logic [32:0] w_acc_n;
    logic [31:0] w_wlo_n;
    logic        w_unused_diff;

    // Multiply: {acc, wlo} holds partial product and remaining multiplier bits.
    assign w_sum  = r_acc + r_mcand;
    assign w_madd = r_wlo[0] ? w_sum : r_acc;

    // Divide: {acc, wlo} holds partial remainder and quotient shifting in at the bottom.
    assign w_shift       = {r_acc, r_wlo[31]};
    assign w_diff        = {1'b0, w_shift} - {2'b00, r_mcand};
    assign w_ge          = !w_diff[34];
    assign w_unused_diff = w_diff[33];

    always_comb begin
        w_acc_n = {1'b0, w_madd[32:1]};
        w_wlo_n = {w_madd[0], r_wlo[31:1]};
        if (r_is_div) begin
            w_acc_n = w_ge ? w_diff[32:0] : w_shift[32:0];
            w_wlo_n = {r_wlo[30:0], w_ge};
        end
    end

    logic [63:0] w_prod;
    logic [63:0] w_prod_neg;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_prod     = {w_acc_n[31:0], w_wlo_n};
    assign w_prod_neg = 64'd0 - w_prod;

    // Final sign fix-up applied to the result of the last iteration.
    always_comb begin
        {w_res_hi, w_res_lo} = r_neg_hi ? w_prod_neg : w_prod;
        if (r_is_div) begin
            if (r_div0) begin
                w_res_lo = 32'hFFFF_FFFF;
                w_res_hi = r_op_a;
            end else begin
                w_res_lo = r_neg_lo ? (32'd0 - w_wlo_n) : w_wlo_n;
                w_res_hi = r_neg_hi ? (32'd0 - w_acc_n[31:0]) : w_acc_n[31:0];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_op_a   <= '0;
            r_acc    <= '0;
            r_wlo    <= '0;
            r_mcand  <= '0;
            r_is_div <= 1'b0;
            r_neg_hi <= 1'b0;
            r_neg_lo <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_md_start) begin
                        // Capture now: forward sources move on while the front end stalls.
                        r_state  <= S_BUSY;
                        r_cnt    <= '0;
                        r_op_a   <= w_fwd_a;
                        r_acc    <= '0;
                        r_wlo    <= w_mag_a;
                        r_mcand  <= {1'b0, w_mag_b};
                        r_is_div <= (MulDivOp == OP_DIV) || (MulDivOp == OP_DIVU);
                        r_neg_hi <= ((MulDivOp == OP_MULT) && (w_neg_a ^ w_neg_b)) ||
                                    ((MulDivOp == OP_DIV) && w_neg_a);
                        r_neg_lo <= w_neg_a ^ w_neg_b;
                        r_div0   <= (w_fwd_b == 32'd0);
                    end else if (w_mt_wr) begin
                        if (MulDivOp == OP_MTHI) r_hi <= w_fwd_a;
                        else                     r_lo <= w_fwd_a;
                    end
                end
                S_BUSY: begin
                    if (Flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_n;
                        r_wlo <= w_wlo_n;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == LAST_ITER) begin
                            r_state <= S_DONE;
                            r_hi    <= w_res_hi;
                            r_lo    <= w_res_lo;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: forwarding muxes, mult/div results and
// latency, operand capture, flush, reset and back-to-back operations.
module tb_execute_stage;

    logic        Clk;
    logic        Rst;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic [31:0] ReadData1_Ex;
    logic [31:0] ReadData2_Ex;
    logic [31:0] Imm_Ex;
    logic        ALUSrc;
    logic [31:0] ALUResult_Mem;
    logic [31:0] WriteData_Wb;
    logic [2:0]  MulDivOp;
    logic        Start;
    logic        Flush;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic [31:0] StoreData;
    logic        Stall;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    execute_stage #(.MD_CYCLES(32)) dut (
        .Clk(Clk), .Rst(Rst), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .ReadData1_Ex(ReadData1_Ex), .ReadData2_Ex(ReadData2_Ex), .Imm_Ex(Imm_Ex),
        .ALUSrc(ALUSrc), .ALUResult_Mem(ALUResult_Mem), .WriteData_Wb(WriteData_Wb),
        .MulDivOp(MulDivOp), .Start(Start), .Flush(Flush),
        .OperandA(OperandA), .OperandB(OperandB), .StoreData(StoreData),
        .Stall(Stall), .Hi(Hi), .Lo(Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Issue one mult/div from IDLE, hold it while stalled, sample Hi/Lo in DONE.
    task automatic md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int n, output logic [31:0] hi, output logic [31:0] lo,
                      output int c0, output int c1);
        ForwardA = 2'b00; ForwardB = 2'b00; ALUSrc = 1'b0;
        ReadData1_Ex = a; ReadData2_Ex = b; MulDivOp = op; Start = 1'b1;
        c0 = cyc_cnt;
        #1;
        n = 0;
        while (Stall && n < 100) begin
            step();
            n++;
        end
        c1 = cyc_cnt;
        hi = Hi; lo = Lo;
        Start = 1'b0; MulDivOp = 3'b000;
        step();
    endtask

    int          n, c0, c1, c2, c3;
    logic [31:0] hi, lo;
    logic [31:0] exp_a [4];

    initial begin
        Rst = 1'b1; ForwardA = 2'b00; ForwardB = 2'b00; ReadData1_Ex = '0; ReadData2_Ex = '0;
        Imm_Ex = '0; ALUSrc = 1'b0; ALUResult_Mem = '0; WriteData_Wb = '0;
        MulDivOp = 3'b000; Start = 1'b0; Flush = 1'b0;
        step(); step();
        Start = 1'b1; MulDivOp = 3'b001; Flush = 1'b1;
        step();
        chk("reset_hi", Hi, 32'h0);
        chk("reset_lo", Lo, 32'h0);
        chk("reset_stall_flushed", {31'b0, Stall}, 32'h0);
        Rst = 1'b0; Start = 1'b0; MulDivOp = 3'b000; Flush = 1'b0;
        step();
        chk("idle_stall", {31'b0, Stall}, 32'h0);

        ReadData1_Ex = 32'd1; ReadData2_Ex = 32'd1; ALUResult_Mem = 32'd2; WriteData_Wb = 32'd3;
        exp_a[0] = 32'd1; exp_a[1] = 32'd3; exp_a[2] = 32'd2; exp_a[3] = 32'd1;
        for (int i = 0; i < 4; i++) begin
            ForwardA = 2'(i); ForwardB = 2'(i);
            #1;
            chk($sformatf("fwdA_%0d", i), OperandA, exp_a[i]);
            chk($sformatf("fwdB_%0d", i), OperandB, exp_a[i]);
            chk($sformatf("store_%0d", i), StoreData, exp_a[i]);
        end
        ALUSrc = 1'b1; Imm_Ex = 32'd7; ForwardB = 2'b10;
        #1;
        chk("imm_opB", OperandB, 32'd7);
        chk("imm_store", StoreData, 32'd2);
        ALUSrc = 1'b0; ForwardA = 2'b00; ForwardB = 2'b00;
        step();

        md(3'b001, 32'hFFFF_FFFE, 32'd3, n, hi, lo, c0, c1);
        chk("mult_stall_cycles", n, 32'd33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        md(3'b010, 32'hFFFF_FFFE, 32'd3, n, hi, lo, c0, c1);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);
        md(3'b011, 32'hFFFF_FFF9, 32'd2, n, hi, lo, c0, c1);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        md(3'b011, 32'd7, 32'hFFFF_FFFE, n, hi, lo, c0, c1);
        chk("div_negdvsr_lo", lo, 32'hFFFF_FFFD);
        chk("div_negdvsr_hi", hi, 32'd1);
        md(3'b100, 32'd100, 32'd7, n, hi, lo, c0, c1);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        md(3'b100, 32'd7, 32'd0, n, hi, lo, c0, c1);
        chk("div0_cycles", n, 32'd33);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 32'd7);
        md(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, n, hi, lo, c0, c1);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0);

        // Operand capture: the MEM forward value changes after cycle 0.
        ForwardA = 2'b10; ALUResult_Mem = 32'd5; ForwardB = 2'b00; ReadData2_Ex = 32'd6;
        MulDivOp = 3'b010; Start = 1'b1;
        #1;
        chk("cap_stall0", {31'b0, Stall}, 32'h1);
        step();
        ALUResult_Mem = 32'd1000; ReadData2_Ex = 32'd9;
        n = 1;
        while (Stall && n < 100) begin step(); n++; end
        chk("cap_cycles", n, 32'd33);
        chk("cap_lo", Lo, 32'd30);
        chk("cap_hi", Hi, 32'd0);
        Start = 1'b0; MulDivOp = 3'b000; ForwardA = 2'b00;
        step();

        // Preload HI/LO, then flush a DIV at BUSY cycle 10.
        ReadData1_Ex = 32'h11; MulDivOp = 3'b101; Start = 1'b1;
        #1;
        chk("mthi_nostall", {31'b0, Stall}, 32'h0);
        step();
        MulDivOp = 3'b110;
        step();
        Start = 1'b0; MulDivOp = 3'b000;
        chk("pre_hi", Hi, 32'h11);
        chk("pre_lo", Lo, 32'h11);
        ReadData1_Ex = 32'd100; ReadData2_Ex = 32'd7; MulDivOp = 3'b011; Start = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("busy10_stall", {31'b0, Stall}, 32'h1);
        Flush = 1'b1; Start = 1'b0;
        step();
        Flush = 1'b0; MulDivOp = 3'b000;
        #1;
        chk("flush_stall", {31'b0, Stall}, 32'h0);
        for (int i = 0; i < 30; i++) step();
        chk("flush_hi", Hi, 32'h11);
        chk("flush_lo", Lo, 32'h11);
        ReadData1_Ex = 32'h55; MulDivOp = 3'b110; Start = 1'b1;
        #1;
        chk("mtlo_nostall", {31'b0, Stall}, 32'h0);
        step();
        Start = 1'b0; MulDivOp = 3'b000;
        chk("mtlo_lo", Lo, 32'h55);
        chk("mtlo_hi", Hi, 32'h11);

        // Flush in IDLE suppresses both an MTHI write and a mult start.
        ReadData1_Ex = 32'h99; MulDivOp = 3'b101; Start = 1'b1; Flush = 1'b1;
        step();
        chk("flushmt_hi", Hi, 32'h11);
        MulDivOp = 3'b001;
        #1;
        chk("flushstart_stall", {31'b0, Stall}, 32'h0);
        step();
        Start = 1'b0; Flush = 1'b0; MulDivOp = 3'b000;
        #1;
        chk("flushstart_idle", {31'b0, Stall}, 32'h0);

        // Reset mid-BUSY.
        ReadData1_Ex = 32'd3; ReadData2_Ex = 32'd5; MulDivOp = 3'b001; Start = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("rstbusy_stall", {31'b0, Stall}, 32'h1);
        Rst = 1'b1;
        step();
        Start = 1'b0; MulDivOp = 3'b000;
        #1;
        chk("rst_hi", Hi, 32'h0);
        chk("rst_lo", Lo, 32'h0);
        chk("rst_stall", {31'b0, Stall}, 32'h0);
        Rst = 1'b0;
        step();

        // Back-to-back MULT;MULT.
        md(3'b001, 32'd3, 32'd5, n, hi, lo, c0, c1);
        chk("b2b1_lo", lo, 32'd15);
        md(3'b001, 32'hFFFF_FFFC, 32'd6, n, hi, lo, c2, c3);
        chk("b2b2_hi", hi, 32'hFFFF_FFFF);
        chk("b2b2_lo", lo, 32'hFFFF_FFE8);
        chk("b2b_gap", c2 - c1, 32'd1);
        chk("b2b_total", c3 - c0 + 1, 32'd68);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
